// File: rtl/aes8_pkg.sv
// Shared constants for the 8-bit-datapath AES-128 core: ShiftRows byte order,
// MixColumns accumulate masks and the per-bank state encoding of the ShiftRows stage.
package aes8_pkg;

  localparam int AES_BLK_BYTES = 16;

  localparam logic [7:0] MC_EN_FIRST = 8'h00;
  localparam logic [7:0] MC_EN_ACC   = 8'hFF;

  // Output position k of a ShiftRows block takes input byte SR_PERM[k] (column-major input).
  localparam logic [3:0] SR_PERM [AES_BLK_BYTES] = '{
    4'd0,  4'd5,  4'd10, 4'd15,
    4'd4,  4'd9,  4'd14, 4'd3,
    4'd8,  4'd13, 4'd2,  4'd7,
    4'd12, 4'd1,  4'd6,  4'd11
  };

  localparam logic [1:0] BANK_EMPTY    = 2'd0;
  localparam logic [1:0] BANK_FILLING  = 2'd1;
  localparam logic [1:0] BANK_FULL     = 2'd2;
  localparam logic [1:0] BANK_DRAINING = 2'd3;

  function automatic logic [3:0] sr_src(input logic [3:0] pos);
    return SR_PERM[pos];
  endfunction

endpackage

// File: rtl/shiftrows_bank.sv
// One 16-byte buffer of the ShiftRows ping-pong pair: written in input order,
// read combinationally in ShiftRows order.
module shiftrows_bank
  import aes8_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata,
  input  logic [3:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [AES_BLK_BYTES];

  // NOTE: the array is small and register-based, so it is cleared on reset to keep
  // stale key-dependent state from lingering; a RAM macro could not be reset like this.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < AES_BLK_BYTES; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[sr_src(raddr)];

endmodule

// File: rtl/shiftrows_8.sv
// Byte-serial ShiftRows stage: two 16-byte banks ping-pong so one block fills
// while the other drains, emitting bytes with the MixColumns accumulate mask.
module shiftrows_8
  import aes8_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [7:0] out_en,
  output logic       out_col_last,
  output logic       out_blk_last
);

  logic       wr_bank;
  logic       rd_bank;
  logic [3:0] wr_cnt;
  logic [3:0] rd_cnt;
  logic [1:0] full;
  logic       accept;
  logic       emit;
  logic       wr_last;
  logic       rd_last;
  logic [7:0] bank_rdata [2];

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;
  assign wr_last   = (wr_cnt == 4'd15);
  assign rd_last   = (rd_cnt == 4'd15);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
    end else if (clear) begin
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
    end else if (accept) begin
      wr_cnt <= wr_cnt + 4'd1;
      if (wr_last) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
    end else if (clear) begin
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
    end else if (emit) begin
      rd_cnt <= rd_cnt + 4'd1;
      if (rd_last) begin
        rd_bank <= ~rd_bank;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    localparam logic BANK_ID = 1'(g);

    logic [1:0] state;
    logic       wr_sel;
    logic       rd_sel;

    assign wr_sel = accept && (wr_bank == BANK_ID);
    assign rd_sel = emit && (rd_bank == BANK_ID);

    // A bank is only written while EMPTY/FILLING because in_ready masks FULL/DRAINING.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= BANK_EMPTY;
      end else if (clear) begin
        state <= BANK_EMPTY;
      end else begin
        case (state)
          BANK_EMPTY:    if (wr_sel)            state <= BANK_FILLING;
          BANK_FILLING:  if (wr_sel && wr_last) state <= BANK_FULL;
          BANK_FULL:     if (rd_sel)            state <= BANK_DRAINING;
          BANK_DRAINING: if (rd_sel && rd_last) state <= BANK_EMPTY;
          default:                              state <= BANK_EMPTY;
        endcase
      end
    end

    assign full[g] = (state == BANK_FULL) || (state == BANK_DRAINING);

    shiftrows_bank u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_sel && !clear),
      .waddr (wr_cnt),
      .wdata (in_data),
      .raddr (rd_cnt),
      .rdata (bank_rdata[g])
    );
  end

  // NOTE: every output gets a default before the if, so no latch is inferred.
  always_comb begin
    out_data     = '0;
    out_en       = MC_EN_FIRST;
    out_col_last = 1'b0;
    out_blk_last = 1'b0;
    if (out_valid) begin
      out_data     = bank_rdata[rd_bank];
      out_en       = (rd_cnt[1:0] == 2'd0) ? MC_EN_FIRST : MC_EN_ACC;
      out_col_last = (rd_cnt[1:0] == 2'd3);
      out_blk_last = rd_last;
    end
  end

endmodule

// File: tb/tb_shiftrows_8.sv
// Scoreboard bench for shiftrows_8: accepted blocks are permuted into an expected
// queue, and every emitted byte, mask and flag is checked against it.
module tb_shiftrows_8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [7:0] out_en;
  logic       out_col_last;
  logic       out_blk_last;

  shiftrows_8 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_en       (out_en),
    .out_col_last (out_col_last),
    .out_blk_last (out_blk_last)
  );

  always #5 clk = ~clk;

  localparam int PERM [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard state
  logic [7:0]  exp_q [$];
  logic [7:0]  part [16];
  int          pcnt   = 0;
  int          opos   = 0;
  int          n_acc  = 0;
  int          n_emit = 0;
  logic        stall_prev = 1'b0;
  logic [17:0] held;

  always @(negedge clk) begin
    if (!rst_n || clear) begin
      pcnt = 0;
      opos = 0;
      stall_prev = 1'b0;
      exp_q.delete();
    end else begin
      if (stall_prev) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_hold", 32'({out_data, out_en, out_col_last, out_blk_last}), 32'(held));
      end
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", 32'(out_valid), 32'd0);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check("out_data", 32'(out_data), 32'(e));
            check("out_en", 32'(out_en), (opos % 4 == 0) ? 32'h00 : 32'hFF);
            check("col_last", 32'(out_col_last), 32'(opos % 4 == 3));
            check("blk_last", 32'(out_blk_last), 32'(opos == 15));
            opos = (opos + 1) % 16;
          end
          n_emit++;
        end
      end else begin
        check("idle_out", 32'({out_data, out_en, out_col_last, out_blk_last}), 32'd0);
      end
      stall_prev = out_valid && !out_ready;
      held = {out_data, out_en, out_col_last, out_blk_last};
      if (in_valid && in_ready) begin
        part[pcnt] = in_data;
        n_acc++;
        if (pcnt == 15) begin
          for (int k = 0; k < 16; k++) exp_q.push_back(part[PERM[k]]);
        end
        pcnt = (pcnt + 1) % 16;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, output int waits);
    bit done;
    done = 1'b0;
    waits = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!done && waits < 200) begin
      @(negedge clk);
      done = in_ready;
      if (!done) waits++;
      tick();
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_drain(input int bound);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < bound) begin
      tick();
      g++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int stalls;
    int e0;
    int a0;
    int k;
    int idx;
    int cyc;

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_en", 32'(out_en), 32'd0);
    check("rst_flags", 32'({out_col_last, out_blk_last}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_after_rst", 32'(out_valid), 32'd0);
    end

    // Single block with first-output latency
    out_ready = 1'b1;
    e0 = n_emit;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("pre_latency_valid", 32'(out_valid), 32'd0);
      send_byte(8'(i), w);
    end
    check("latency_valid", 32'(out_valid), 32'd1);
    check("first_byte", 32'(out_data), 32'h00);
    wait_drain(40);
    tick();
    check("blk1_count", 32'(n_emit - e0), 32'd16);

    // Three back-to-back blocks: no input stalls, contiguous output
    e0 = n_emit;
    stalls = 0;
    for (int i = 0; i < 48; i++) begin
      send_byte(8'(i), w);
      stalls += w;
    end
    check("b2b_in_stalls", 32'(stalls), 32'd0);
    for (int i = 0; i < 16; i++) tick();
    check("b2b_contiguous", 32'(n_emit - e0), 32'd48);
    check("b2b_done_valid", 32'(out_valid), 32'd0);

    // Backpressure: 32 bytes absorbed, then in_ready drops
    out_ready = 1'b0;
    a0 = n_acc;
    k = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 34; i++) begin
      in_data = 8'(k);
      @(negedge clk);
      if (in_ready) k++;
      tick();
    end
    in_valid = 1'b0;
    check("bp_accepted", 32'(n_acc - a0), 32'd32);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_hold_data", 32'(out_data), 32'h00);
    check("bp_hold_en", 32'(out_en), 32'h00);
    e0 = n_emit;
    out_ready = 1'b1;
    wait_drain(80);
    check("bp_drained", 32'(n_emit - e0), 32'd32);

    // Abort by clear (with a same-cycle accept attempt), then by reset pulse
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 7; i++) send_byte(8'(8'h50 + i), w);
      if (rep == 0) begin
        in_valid = 1'b1; in_data = 8'h57; clear = 1'b1;
        tick();
        clear = 1'b0; in_valid = 1'b0;
      end else begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      e0 = n_emit;
      for (int i = 0; i < 20; i++) tick();
      check("abort_no_out", 32'(n_emit - e0), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 16; i++) send_byte(8'(8'hA0 + i), w);
      check("abort_first", 32'(out_data), 32'hA0);
      wait_drain(40);
      check("abort_blk", 32'(n_emit - e0), 32'd16);
    end

    // Random valid/ready over 200 blocks
    e0 = n_emit;
    idx = 0;
    cyc = 0;
    while (idx < 3200 && cyc < 40000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'(idx * 7 + 3);
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("rand_sent", 32'(idx), 32'd3200);
    wait_drain(100);
    check("rand_emitted", 32'(n_emit - e0), 32'd3200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
